sm_gpio_bank: RTL and testbench

SM_GPIO_BANK -- requirements
Module: sm_gpio_bank

---
 rtl/sm_gpio_bank.sv | 138 +++++++++++++
 tb/tb_sm_gpio_bank.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sm_gpio_bank.sv
// GPIO pad bank shared by NUM_SM state machines and a host port, with per-SM rotated input views and WAIT flags.
// Define GPIO_INPUT_SYNC_EN to pass pad inputs through a two-flop synchroniser (2 cycles extra input latency).
// Wait FSM: state | meaning
//   IDLE  | no wait pending, out_waitMet held low
//   ARMED | sampling gpioS[waitIdx] against waitPol every cycle
module sm_gpio_bank #(
    parameter int GPIO_W = 32,
    parameter int NUM_SM = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SM-1:0]           in_smEnable,
    input  logic [NUM_SM*GPIO_W-1:0]    in_pinsWriteData,
    input  logic [NUM_SM*GPIO_W-1:0]    in_pinsWriteMask,
    input  logic [NUM_SM*GPIO_W-1:0]    in_pinDirsWriteData,
    input  logic [NUM_SM*GPIO_W-1:0]    in_pinDirsWriteMask,
    input  logic                        in_busWriteEn,
    input  logic                        in_busSelDirs,
    input  logic [GPIO_W-1:0]           in_busData,
    input  logic [GPIO_W-1:0]           in_busMask,
    input  logic [NUM_SM*$clog2(GPIO_W)-1:0] in_inBase,
    input  logic [NUM_SM-1:0]           in_waitEnable,
    input  logic [NUM_SM-1:0]           in_waitPol,
    input  logic [NUM_SM*$clog2(GPIO_W)-1:0] in_waitIdx,
    input  logic [GPIO_W-1:0]           in_GPIO,
    output logic [GPIO_W-1:0]           out_padOut,
    output logic [GPIO_W-1:0]           out_padOe,
    output logic [NUM_SM*GPIO_W-1:0]    out_inGPIOmappedData,
    output logic [NUM_SM-1:0]           out_waitMet
);

    localparam int IDX_W = $clog2(GPIO_W);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } wait_st_e;

    logic [GPIO_W-1:0]   pins_q, pins_d;
    logic [GPIO_W-1:0]   dirs_q, dirs_d;
    logic [GPIO_W-1:0]   gpio_s;
    logic [2*GPIO_W-1:0] rot_tmp;
    wait_st_e            state_q [NUM_SM];
    wait_st_e            state_d [NUM_SM];
    logic [NUM_SM-1:0]   met_q, met_d;

`ifdef GPIO_INPUT_SYNC_EN
    logic [GPIO_W-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_GPIO;
            sync2_q <= sync1_q;
        end
    end

    assign gpio_s = sync2_q;
`else
    assign gpio_s = in_GPIO;
`endif

    // Host first, then SMs in ascending order so the highest enabled SM wins per bit.
    always_comb begin
        pins_d = pins_q;
        dirs_d = dirs_q;
        if (in_busWriteEn && !in_busSelDirs)
            pins_d = (pins_d & ~in_busMask) | (in_busData & in_busMask);
        if (in_busWriteEn && in_busSelDirs)
            dirs_d = (dirs_d & ~in_busMask) | (in_busData & in_busMask);
        for (int i = 0; i < NUM_SM; i++) begin
            if (in_smEnable[i]) begin
                pins_d = (pins_d & ~in_pinsWriteMask[i*GPIO_W +: GPIO_W])
                       | (in_pinsWriteData[i*GPIO_W +: GPIO_W] & in_pinsWriteMask[i*GPIO_W +: GPIO_W]);
                dirs_d = (dirs_d & ~in_pinDirsWriteMask[i*GPIO_W +: GPIO_W])
                       | (in_pinDirsWriteData[i*GPIO_W +: GPIO_W] & in_pinDirsWriteMask[i*GPIO_W +: GPIO_W]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pins_q <= '0;
            dirs_q <= '0;
        end else begin
            pins_q <= pins_d;
            dirs_q <= dirs_d;
        end
    end

    assign out_padOut = pins_q;
    assign out_padOe  = dirs_q;

    // Rotate right by IN_BASE: shifting the doubled vector keeps the wrap-around bits.
    always_comb begin
        rot_tmp              = '0;
        out_inGPIOmappedData = '0;
        for (int i = 0; i < NUM_SM; i++) begin
            rot_tmp = {gpio_s, gpio_s} >> in_inBase[i*IDX_W +: IDX_W];
            out_inGPIOmappedData[i*GPIO_W +: GPIO_W] = rot_tmp[GPIO_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SM; i++) state_q[i] <= ST_IDLE;
            met_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SM; i++) state_q[i] <= state_d[i];
            met_q <= met_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SM; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                ST_IDLE:  if (in_waitEnable[i] && in_smEnable[i]) state_d[i] = ST_ARMED;
                ST_ARMED: if (!in_waitEnable[i] || !in_smEnable[i]) state_d[i] = ST_IDLE;
                default:  state_d[i] = ST_IDLE;
            endcase
        end
    end

    // The flag is only sampled while the FSM stays armed, so disarming clears it on the next edge.
    always_comb begin
        met_d = '0;
        for (int i = 0; i < NUM_SM; i++) begin
            if (state_q[i] == ST_ARMED && state_d[i] == ST_ARMED)
                met_d[i] = (gpio_s[in_waitIdx[i*IDX_W +: IDX_W]] == in_waitPol[i]);
        end
    end

    assign out_waitMet = met_q;

endmodule

// File: tb/tb_sm_gpio_bank.sv
// Self-checking bench for sm_gpio_bank (GPIO_W=32, NUM_SM=4): write arbitration table, rotate, wait and reset sequences.
module tb_sm_gpio_bank;

    localparam int GPIO_W = 32;
    localparam int NUM_SM = 4;
    localparam int IDX_W  = 5;
    localparam int NV     = 10;
`ifdef GPIO_INPUT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_SM-1:0]        in_smEnable;
    logic [NUM_SM*GPIO_W-1:0] in_pinsWriteData, in_pinsWriteMask;
    logic [NUM_SM*GPIO_W-1:0] in_pinDirsWriteData, in_pinDirsWriteMask;
    logic                     in_busWriteEn, in_busSelDirs;
    logic [GPIO_W-1:0]        in_busData, in_busMask;
    logic [NUM_SM*IDX_W-1:0]  in_inBase, in_waitIdx;
    logic [NUM_SM-1:0]        in_waitEnable, in_waitPol;
    logic [GPIO_W-1:0]        in_GPIO;
    logic [GPIO_W-1:0]        out_padOut, out_padOe;
    logic [NUM_SM*GPIO_W-1:0] out_inGPIOmappedData;
    logic [NUM_SM-1:0]        out_waitMet;

    sm_gpio_bank #(.GPIO_W(GPIO_W), .NUM_SM(NUM_SM)) dut (
        .clk(clk), .reset(reset), .in_smEnable(in_smEnable),
        .in_pinsWriteData(in_pinsWriteData), .in_pinsWriteMask(in_pinsWriteMask),
        .in_pinDirsWriteData(in_pinDirsWriteData), .in_pinDirsWriteMask(in_pinDirsWriteMask),
        .in_busWriteEn(in_busWriteEn), .in_busSelDirs(in_busSelDirs),
        .in_busData(in_busData), .in_busMask(in_busMask), .in_inBase(in_inBase),
        .in_waitEnable(in_waitEnable), .in_waitPol(in_waitPol), .in_waitIdx(in_waitIdx),
        .in_GPIO(in_GPIO), .out_padOut(out_padOut), .out_padOe(out_padOe),
        .out_inGPIOmappedData(out_inGPIOmappedData), .out_waitMet(out_waitMet)
    );

    always #5 clk = ~clk;

    typedef struct {
        string                    name;
        logic [NUM_SM-1:0]        en;
        logic [NUM_SM*GPIO_W-1:0] pd, pm, dd, dm;
        logic                     bwe, bsel;
        logic [GPIO_W-1:0]        bd, bm;
        logic [GPIO_W-1:0]        exp_out, exp_oe;
    } vec_t;

    typedef struct {
        string             name;
        logic [GPIO_W-1:0] exp_out, exp_oe;
    } sb_t;

    vec_t vecs [NV];
    sb_t  exp_q [$];
    sb_t  e;
    int   n_vec = 0;
    int   n_err = 0;

    logic [GPIO_W-1:0] rot_g   [2];
    logic [GPIO_W-1:0] rot_exp [2][NUM_SM];

    function automatic vec_t mk(input string nm, input logic [3:0] en, input logic bwe, input logic bsel,
                                input logic [31:0] bd, input logic [31:0] bm,
                                input logic [31:0] eo, input logic [31:0] ee);
        vec_t v;
        v.name = nm; v.en = en; v.bwe = bwe; v.bsel = bsel; v.bd = bd; v.bm = bm;
        v.pd = '0; v.pm = '0; v.dd = '0; v.dm = '0;
        v.exp_out = eo; v.exp_oe = ee;
        return v;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        in_smEnable = '0;
        in_pinsWriteData = '0; in_pinsWriteMask = '0;
        in_pinDirsWriteData = '0; in_pinDirsWriteMask = '0;
        in_busWriteEn = 1'b0; in_busSelDirs = 1'b0; in_busData = '0; in_busMask = '0;
    endtask

    task automatic drive(input vec_t v);
        in_smEnable = v.en;
        in_pinsWriteData = v.pd; in_pinsWriteMask = v.pm;
        in_pinDirsWriteData = v.dd; in_pinDirsWriteMask = v.dm;
        in_busWriteEn = v.bwe; in_busSelDirs = v.bsel; in_busData = v.bd; in_busMask = v.bm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected values accumulate from the reset state through the table.
        vecs[0] = mk("prio_sm3_over_sm0", 4'hF, 0, 0, 0, 0, 32'h0000_00F0, 32'h0000_0000);
        vecs[0].pd[0*32 +: 32] = 32'h0000_00FF; vecs[0].pm[0*32 +: 32] = 32'h0000_00FF;
        vecs[0].pd[3*32 +: 32] = 32'h0000_0000; vecs[0].pm[3*32 +: 32] = 32'h0000_000F;
        vecs[1] = mk("host_dirs_sm1_bit0", 4'h2, 1, 1, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_00F0, 32'hFFFF_0001);
        vecs[1].dd[1*32 +: 32] = 32'h1; vecs[1].dm[1*32 +: 32] = 32'h1;
        vecs[2] = mk("sm2_disabled", 4'hB, 0, 0, 0, 0, 32'h0000_00F0, 32'hFFFF_0001);
        vecs[2].pd[2*32 +: 32] = 32'h1234_5678; vecs[2].pm[2*32 +: 32] = 32'hFFFF_FFFF;
        vecs[2].dd[2*32 +: 32] = 32'h0;         vecs[2].dm[2*32 +: 32] = 32'hFFFF_FFFF;
        vecs[3] = mk("disjoint_sm_writes", 4'hF, 0, 0, 0, 0, 32'h0300_005A, 32'hFFFF_0001);
        vecs[3].pd[0*32 +: 32] = 32'h0000_000A; vecs[3].pm[0*32 +: 32] = 32'h0000_000F;
        vecs[3].pd[1*32 +: 32] = 32'h0000_0050; vecs[3].pm[1*32 +: 32] = 32'h0000_00F0;
        vecs[3].pd[2*32 +: 32] = 32'h0300_0000; vecs[3].pm[2*32 +: 32] = 32'h0F00_0000;
        vecs[4] = mk("pins_and_dirs_same_bit", 4'hF, 0, 0, 0, 0, 32'h8300_005A, 32'h7FFF_0001);
        vecs[4].pd[1*32 +: 32] = 32'h8000_0000; vecs[4].pm[1*32 +: 32] = 32'h8000_0000;
        vecs[4].dd[2*32 +: 32] = 32'h0000_0000; vecs[4].dm[2*32 +: 32] = 32'h8000_0000;
        vecs[5] = mk("mask_zero_no_effect", 4'hF, 1, 0, 32'hFFFF_FFFF, 32'h0, 32'h8300_005A, 32'h7FFF_0001);
        vecs[5].pd = '1; vecs[5].dd = '1;
        vecs[6] = mk("host_pins_sm0_override", 4'h1, 1, 0, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'h8300_FFF0, 32'h7FFF_0001);
        vecs[6].pd[0*32 +: 32] = 32'h0; vecs[6].pm[0*32 +: 32] = 32'h0000_000F;
        vecs[7] = mk("host_strobe_low", 4'h0, 0, 1, 32'h0, 32'hFFFF_FFFF, 32'h8300_FFF0, 32'h7FFF_0001);
        vecs[8] = mk("host_dirs_target_only", 4'h0, 1, 1, 32'h0, 32'h0000_00FF, 32'h8300_FFF0, 32'h7FFF_0000);
        vecs[9] = mk("prio_sm3_over_sm1_dirs", 4'hA, 0, 0, 0, 0, 32'h8300_FFF0, 32'h7FFF_00F0);
        vecs[9].dd[1*32 +: 32] = 32'hFF; vecs[9].dm[1*32 +: 32] = 32'hFF;
        vecs[9].dd[3*32 +: 32] = 32'h00; vecs[9].dm[3*32 +: 32] = 32'h0F;

        rot_g[0] = 32'h8000_0001;
        rot_exp[0][0] = 32'h0000_0003; rot_exp[0][1] = 32'h8000_0001;
        rot_exp[0][2] = 32'h1800_0000; rot_exp[0][3] = 32'h0180_0000;
        rot_g[1] = 32'h1234_5678;
        rot_exp[1][0] = 32'h2468_ACF0; rot_exp[1][1] = 32'h1234_5678;
        rot_exp[1][2] = 32'h8123_4567; rot_exp[1][3] = 32'h7812_3456;

        idle();
        reset = 1'b1; in_GPIO = '0; in_inBase = '0; in_waitIdx = '0;
        in_waitEnable = '0; in_waitPol = '0;
        step(); step();
        reset = 1'b0;
        check("reset_padOut", 128'(out_padOut), 128'(0));
        check("reset_padOe", 128'(out_padOe), 128'(0));
        check("reset_waitMet", 128'(out_waitMet), 128'(0));

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            exp_q.push_back('{vecs[i].name, vecs[i].exp_out, vecs[i].exp_oe});
            step();
            idle();
            e = exp_q.pop_front();
            check({e.name, "_out"}, 128'(out_padOut), 128'(e.exp_out));
            check({e.name, "_oe"}, 128'(out_padOe), 128'(e.exp_oe));
        end

        in_inBase = {5'd8, 5'd4, 5'd0, 5'd31};
        for (int r = 0; r < 2; r++) begin
            in_GPIO = rot_g[r];
            for (int c = 0; c < LAT; c++) step();
            #1;
            for (int s = 0; s < NUM_SM; s++)
                check($sformatf("rotate_g%0d_sm%0d", r, s),
                      128'(out_inGPIOmappedData[s*GPIO_W +: GPIO_W]), 128'(rot_exp[r][s]));
        end

        // SM1 waits for pad 5 high, SM2 for pad 5 low.
        in_GPIO = '0;
        in_smEnable = 4'hF;
        in_waitIdx = {5'd0, 5'd5, 5'd5, 5'd0};
        in_waitPol = 4'b0010;
        in_waitEnable = 4'b0110;
        repeat (LAT + 3) step();
        check("wait_low_phase", 128'(out_waitMet), 128'(4'b0100));
        in_GPIO[5] = 1'b1;
        for (int c = 1; c <= LAT + 1; c++) begin
            step();
            check($sformatf("wait_edge_c%0d", c), 128'(out_waitMet),
                  (c <= LAT) ? 128'(4'b0100) : 128'(4'b0010));
        end
        in_waitIdx[1*IDX_W +: IDX_W] = 5'd6;
        step();
        check("wait_idx_change", 128'(out_waitMet), 128'(4'b0000));
        in_waitIdx[1*IDX_W +: IDX_W] = 5'd5;
        step();
        check("wait_idx_back", 128'(out_waitMet), 128'(4'b0010));
        in_smEnable[1] = 1'b0;
        step();
        check("wait_disable_clears", 128'(out_waitMet), 128'(4'b0000));
        in_waitEnable = '0;
        in_GPIO = '0;
        idle();
        repeat (LAT + 1) step();

        in_busWriteEn = 1'b1; in_busSelDirs = 1'b0;
        in_busData = 32'hA5A5_A5A5; in_busMask = 32'hFFFF_FFFF;
        step();
        idle();
        check("pins_a5", 128'(out_padOut), 128'(32'hA5A5_A5A5));

        // Arm SM0 on pad 3 high, then reset while the pad rises and SM0 writes.
        in_smEnable = 4'h1;
        in_waitIdx = {5'd0, 5'd0, 5'd0, 5'd3};
        in_waitPol = 4'b0001;
        in_waitEnable = 4'b0001;
        repeat (2) step();
        check("pre_reset_wait_pending", 128'(out_waitMet), 128'(0));
        in_GPIO[3] = 1'b1;
        in_pinsWriteData[0 +: 32] = 32'hFFFF_FFFF; in_pinsWriteMask[0 +: 32] = 32'hFFFF_FFFF;
        in_pinDirsWriteData[0 +: 32] = 32'hFFFF_FFFF; in_pinDirsWriteMask[0 +: 32] = 32'hFFFF_FFFF;
        reset = 1'b1;
        step();
        check("rst_write_padOut", 128'(out_padOut), 128'(0));
        check("rst_write_padOe", 128'(out_padOe), 128'(0));
        check("rst_write_waitMet", 128'(out_waitMet), 128'(0));
        for (int c = 0; c < LAT + 2; c++) begin
            step();
            check($sformatf("rst_hold_waitMet_c%0d", c), 128'(out_waitMet), 128'(0));
        end
        in_waitEnable = '0;
        idle();
        reset = 1'b0;
        repeat (LAT + 2) step();
        check("post_reset_waitMet", 128'(out_waitMet), 128'(0));
        check("post_reset_padOut", 128'(out_padOut), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
